// File: rtl/mips_cpu_run_pkg.sv
// Shared types and default timing constants for the mips_cpu run controller.
package mips_cpu_run_pkg;

    // Run sequencing phases, from host request through CPU reset, wait, run and completion.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST      = 3'd1,
        ST_WAIT_ACT = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4
    } run_state_t;

    localparam int unsigned DEF_RESET_CYCLES   = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100;
    localparam int unsigned DEF_ACTIVE_WAIT    = 2;
    localparam int unsigned DEF_CNT_W          = 32;

endpackage

// File: rtl/mips_cpu_run_ctrl.sv
// Run controller for a mips_cpu_harvard instance: pulses the CPU reset, gates
// clk_enable (free-run or single-step), counts enabled RUN cycles, detects
// program end via cpu_active falling, enforces a timeout and captures v0.
module mips_cpu_run_ctrl
    import mips_cpu_run_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned ACTIVE_WAIT    = DEF_ACTIVE_WAIT,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic             i_cpu_active,
    input  logic [31:0]      i_cpu_register_v0,
    output logic             o_cpu_reset,
    output logic             o_cpu_clk_enable,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timed_out,
    output logic             o_no_active,
    output logic [31:0]      o_result,
    output logic [CNT_W-1:0] o_cycle_count
);

    // The phase counter is shared by RST and WAIT_ACT, so size it for the longer of the two.
    localparam int unsigned PH_MAX = (RESET_CYCLES > ACTIVE_WAIT) ? RESET_CYCLES : ACTIVE_WAIT;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $error("RESET_CYCLES must be at least 1");
    end
    if (ACTIVE_WAIT < 1) begin : g_bad_active_wait
        $error("ACTIVE_WAIT must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_low
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    if ((64'(TIMEOUT_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_timeout_width
        $error("TIMEOUT_CYCLES must be less than 2**CNT_W");
    end

    run_state_t        r_state;
    run_state_t        w_state_nxt;
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phase_nxt;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [31:0]       r_result;
    logic [31:0]       w_result_nxt;
    logic              r_timed_out;
    logic              w_timed_out_nxt;
    logic              r_no_active;
    logic              w_no_active_nxt;
    logic              w_clk_en;
    logic              w_run_en;

    // Next-state, datapath updates and CPU-facing outputs from the registered state.
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_count_nxt     = r_cycle_count;
        w_result_nxt    = r_result;
        w_timed_out_nxt = r_timed_out;
        w_no_active_nxt = r_no_active;
        w_clk_en        = 1'b0;
        w_run_en        = i_step_mode ? i_step : 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_result_nxt    = '0;
                    w_count_nxt     = '0;
                    w_timed_out_nxt = 1'b0;
                    w_no_active_nxt = 1'b0;
                    w_phase_nxt     = '0;
                    w_state_nxt     = ST_RST;
                end
            end
            ST_RST: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_clk_en = 1'b1;
                    if (r_phase == PH_W'(RESET_CYCLES - 1)) begin
                        w_phase_nxt = '0;
                        w_state_nxt = ST_WAIT_ACT;
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end
            end
            ST_WAIT_ACT: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_clk_en = 1'b1;
                    if (i_cpu_active) begin
                        w_state_nxt = ST_RUN;
                    end else if (r_phase == PH_W'(ACTIVE_WAIT - 1)) begin
                        w_no_active_nxt = 1'b1;
                        w_result_nxt    = '0;
                        w_state_nxt     = ST_DONE;
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_clk_en = w_run_en;
                    if (w_run_en) begin
                        w_count_nxt = r_cycle_count + 1'b1;
                    end
                    // Normal completion is checked first so a same-edge timeout never flags.
                    if (!i_cpu_active) begin
                        w_result_nxt = i_cpu_register_v0;
                        w_state_nxt  = ST_DONE;
                    end else if (w_run_en && (w_count_nxt == CNT_W'(TIMEOUT_CYCLES))) begin
                        w_timed_out_nxt = 1'b1;
                        w_result_nxt    = i_cpu_register_v0;
                        w_state_nxt     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Phase counter, cycle counter, captured result and sticky flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase       <= '0;
            r_cycle_count <= '0;
            r_result      <= '0;
            r_timed_out   <= 1'b0;
            r_no_active   <= 1'b0;
        end else begin
            r_phase       <= w_phase_nxt;
            r_cycle_count <= w_count_nxt;
            r_result      <= w_result_nxt;
            r_timed_out   <= w_timed_out_nxt;
            r_no_active   <= w_no_active_nxt;
        end
    end

    // Host-visible status and CPU control outputs.
    always_comb begin
        o_cpu_reset      = i_reset | (r_state == ST_RST);
        o_cpu_clk_enable = w_clk_en;
        o_busy           = (r_state != ST_IDLE);
        o_done           = (r_state == ST_DONE);
        o_timed_out      = r_timed_out;
        o_no_active      = r_no_active;
        o_result         = r_result;
        o_cycle_count    = r_cycle_count;
    end

endmodule

// File: tb/tb_mips_cpu_run_ctrl.sv
// Bench for mips_cpu_run_ctrl: a stub CPU, a rule-level reference model checked
// every cycle, and directed runs with hand-computed literal expectations.
module tb_mips_cpu_run_ctrl;

    localparam int RC = 2;
    localparam int TO = 100;
    localparam int AW = 2;

    localparam int M_IDLE = 0;
    localparam int M_RST  = 1;
    localparam int M_WAIT = 2;
    localparam int M_RUN  = 3;
    localparam int M_DONE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        cpu_active;
    logic [31:0] v0;
    logic        cpu_reset;
    logic        cpu_clk_enable;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic        no_active;
    logic [31:0] result;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    // Stub CPU: counts enabled cycles since its reset, stays active for prog_len of them.
    int          stub = 0;
    int          prog_len = 5;
    logic [31:0] v0_final = 32'd7;
    bit          hold_inactive = 1'b0;

    // Reference model state.
    int          m_mode = M_IDLE;
    int          m_age = 0;
    int          m_cnt = 0;
    logic [31:0] m_res = '0;
    bit          m_to = 1'b0;
    bit          m_na = 1'b0;

    // Monitors read by the directed tests.
    int done_cnt = 0;
    int rst_hi_cnt = 0;
    int en_cnt = 0;

    mips_cpu_run_ctrl #(
        .RESET_CYCLES(RC),
        .TIMEOUT_CYCLES(TO),
        .ACTIVE_WAIT(AW),
        .CNT_W(32)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_start(start),
        .i_abort(abort),
        .i_step_mode(step_mode),
        .i_step(step),
        .i_cpu_active(cpu_active),
        .i_cpu_register_v0(v0),
        .o_cpu_reset(cpu_reset),
        .o_cpu_clk_enable(cpu_clk_enable),
        .o_busy(busy),
        .o_done(done),
        .o_timed_out(timed_out),
        .o_no_active(no_active),
        .o_result(result),
        .o_cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_reset) stub <= 0;
        else if (cpu_clk_enable) stub <= stub + 1;
    end

    assign cpu_active = hold_inactive ? 1'b0 : (stub < prog_len);
    assign v0 = (stub >= prog_len) ? v0_final : 32'(stub);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what a run controller must do at each edge, stated as run rules.
    always @(posedge clk or posedge rst) begin
        bit en;
        if (rst) begin
            m_mode = M_IDLE; m_age = 0; m_cnt = 0; m_res = '0; m_to = 1'b0; m_na = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (start && !abort) begin
                    m_mode = M_RST; m_age = 0; m_cnt = 0; m_res = '0; m_to = 1'b0; m_na = 1'b0;
                end
                M_RST: if (abort) m_mode = M_IDLE;
                       else begin
                           m_age++;
                           if (m_age == RC) begin m_mode = M_WAIT; m_age = 0; end
                       end
                M_WAIT: if (abort) m_mode = M_IDLE;
                        else if (cpu_active) m_mode = M_RUN;
                        else begin
                            m_age++;
                            if (m_age == AW) begin m_na = 1'b1; m_res = '0; m_mode = M_DONE; end
                        end
                M_RUN: if (abort) m_mode = M_IDLE;
                       else begin
                           en = step_mode ? step : 1'b1;
                           if (en) m_cnt++;
                           if (!cpu_active) begin m_res = v0; m_mode = M_DONE; end
                           else if (en && m_cnt == TO) begin m_to = 1'b1; m_res = v0; m_mode = M_DONE; end
                       end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic en_exp;
        en_exp = 1'b0;
        if (!rst && !abort) begin
            if (m_mode == M_RST || m_mode == M_WAIT) en_exp = 1'b1;
            else if (m_mode == M_RUN) en_exp = step_mode ? step : 1'b1;
        end
        chk("cpu_reset", 64'(cpu_reset), 64'(rst || m_mode == M_RST));
        chk("cpu_clk_enable", 64'(cpu_clk_enable), 64'(en_exp));
        chk("busy", 64'(busy), 64'(m_mode != M_IDLE));
        chk("done", 64'(done), 64'(m_mode == M_DONE));
        chk("result", 64'(result), 64'(m_res));
        chk("cycle_count", 64'(cycle_count), 64'(m_cnt));
        chk("timed_out", 64'(timed_out), 64'(m_to));
        chk("no_active", 64'(no_active), 64'(m_na));
        if (done) done_cnt++;
        if (cpu_reset && !rst) rst_hi_cnt++;
        if (cpu_clk_enable) en_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int lat);
        bit seen;
        seen = 1'b0;
        lat = 0;
        for (int i = 1; i <= max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat = i;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int b_done;
        int b_rst;
        int b_en;

        rst = 1'b1;
        #12;
        chk("reset_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_count", 64'(cycle_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Free-run program ending after 5 RUN cycles with v0=7; start pulsed again in DONE.
        prog_len = 5; v0_final = 32'd7;
        b_done = done_cnt; b_rst = rst_hi_cnt;
        start_run();
        wait_done(60, lat);
        chk("addu_latency", 64'(lat), 64'd9);
        chk("addu_result", 64'(result), 64'd7);
        chk("addu_count", 64'(cycle_count), 64'd5);
        chk("addu_timed_out", 64'(timed_out), 64'd0);
        chk("addu_no_active", 64'(no_active), 64'd0);
        chk("addu_cpu_reset_cycles", 64'(rst_hi_cnt - b_rst), 64'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("addu_start_in_done_ignored", 64'(busy), 64'd0);
        chk("addu_done_pulses", 64'(done_cnt - b_done), 64'd1);

        // Endless program: timeout on the 100th enabled cycle, v0 is the stub count then.
        prog_len = 1000000;
        start_run();
        wait_done(200, lat);
        chk("to_latency", 64'(lat), 64'd104);
        chk("to_count", 64'(cycle_count), 64'd100);
        chk("to_timed_out", 64'(timed_out), 64'd1);
        chk("to_result", 64'(result), 64'd100);
        chk("to_no_active", 64'(no_active), 64'd0);
        tick();

        // Abort together with start on the 10th RUN cycle.
        b_done = done_cnt;
        start_run();
        repeat (12) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_count", 64'(cycle_count), 64'd9);
        chk("abort_flags_cleared", 64'(timed_out), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        repeat (5) tick();
        chk("abort_no_done", 64'(done_cnt - b_done), 64'd0);
        chk("abort_stays_idle", 64'(busy), 64'd0);

        // CPU that never raises active.
        hold_inactive = 1'b1;
        start_run();
        wait_done(20, lat);
        chk("na_latency", 64'(lat), 64'd5);
        chk("na_flag", 64'(no_active), 64'd1);
        chk("na_result", 64'(result), 64'd0);
        chk("na_count", 64'(cycle_count), 64'd0);
        tick();
        hold_inactive = 1'b0;

        // Program end and timeout on the same edge: normal completion wins.
        prog_len = 100; v0_final = 32'h0000ABCD;
        start_run();
        wait_done(200, lat);
        chk("tie_count", 64'(cycle_count), 64'd100);
        chk("tie_timed_out", 64'(timed_out), 64'd0);
        chk("tie_result", 64'(result), 64'h0000ABCD);
        chk("tie_no_active_cleared", 64'(no_active), 64'd0);
        tick();

        // Single-step: three step pulses four cycles apart.
        step_mode = 1'b1; prog_len = 4; v0_final = 32'h33;
        start_run();
        repeat (3) tick();
        b_en = en_cnt;
        for (int k = 0; k < 3; k++) begin
            repeat (3) tick();
            step = 1'b1;
            tick();
            step = 1'b0;
        end
        wait_done(50, lat);
        chk("step_enabled_cycles", 64'(en_cnt - b_en), 64'd3);
        chk("step_count", 64'(cycle_count), 64'd3);
        chk("step_timed_out", 64'(timed_out), 64'd0);
        chk("step_result", 64'(result), 64'h33);
        tick();

        // Single-step with gaps long enough that wall time exceeds the timeout.
        start_run();
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            repeat (49) tick();
            step = 1'b1;
            tick();
            step = 1'b0;
        end
        wait_done(100, lat);
        chk("gap_count", 64'(cycle_count), 64'd3);
        chk("gap_timed_out", 64'(timed_out), 64'd0);
        step_mode = 1'b0;
        tick();

        // Asynchronous reset between edges in the middle of RUN.
        prog_len = 1000000;
        start_run();
        repeat (8) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("areset_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("areset_busy", 64'(busy), 64'd0);
        chk("areset_enable", 64'(cpu_clk_enable), 64'd0);
        chk("areset_done", 64'(done), 64'd0);
        chk("areset_count", 64'(cycle_count), 64'd0);
        chk("areset_result", 64'(result), 64'd0);
        @(posedge clk);
        #1;
        chk("areset_held_cpu_reset", 64'(cpu_reset), 64'd1);
        rst = 1'b0;
        tick();
        chk("areset_idle_after", 64'(busy), 64'd0);

        // Clean run after the reset.
        prog_len = 5; v0_final = 32'd7;
        start_run();
        wait_done(60, lat);
        chk("final_latency", 64'(lat), 64'd9);
        chk("final_result", 64'(result), 64'd7);
        chk("final_count", 64'(cycle_count), 64'd5);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_run_ctrl.md
Name: mips_cpu_run_ctrl

Overview:
- Sequences a mips_cpu_harvard instance: issues the CPU reset pulse, gates clk_enable (free-run or single-step), counts executed cycles, detects program end (active falling), enforces a cycle timeout, and captures register_v0 as the run result.
- Sits between a host or bench controller and the CPU.
- Replaces ad-hoc reset, timeout and result logic in benches and FPGA top levels.

Parameters:
- RESET_CYCLES, 2: cycles cpu_reset is held high per run (at least 1).
- TIMEOUT_CYCLES, 100: maximum enabled cycles in RUN before forced stop (at least 1).
- ACTIVE_WAIT, 2: cycles allowed after reset release for cpu_active to rise.
- CNT_W, 32: width of cycle_count; TIMEOUT_CYCLES must be less than 2^CNT_W (elaboration check).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- abort  in  1  cancel the current run
- step_mode  in  1  1 = single-step mode
- step  in  1  in step mode, grants exactly one enabled cycle
- cpu_active  in  1  CPU active output
- cpu_register_v0  in  32  CPU v0 register
- cpu_reset  out  1  drives CPU reset
- cpu_clk_enable  out  1  drives CPU clk_enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on run completion
- timed_out  out  1  sticky until next start; run hit TIMEOUT_CYCLES
- no_active  out  1  sticky until next start; CPU never raised active
- result  out  32  captured v0, held until next start
- cycle_count  out  CNT_W  enabled RUN cycles in current/last run

Behaviour:
- Async reset:
  - state goes to IDLE; all registered outputs and counters are 0.
  - cpu_reset = reset OR (state==RST), so the CPU is held in reset while the controller is.
- States: IDLE, RST, WAIT_ACT, RUN, DONE.
- IDLE:
  - cpu_clk_enable=0, busy=0.
  - start=1 and abort=0: clear result, cycle_count, timed_out and no_active; go to RST.
- RST:
  - cpu_reset=1, cpu_clk_enable=1.
  - Stays exactly RESET_CYCLES cycles, then goes to WAIT_ACT.
- WAIT_ACT:
  - cpu_reset=0, cpu_clk_enable=1.
  - cpu_active=1: go to RUN.
  - ACTIVE_WAIT cycles pass without active: set no_active=1, result=0, go to DONE.
- RUN:
  - cpu_clk_enable = step_mode ? step : 1 (combinational from the registered state).
  - cycle_count increments on each edge where cpu_clk_enable=1.
  - cpu_active=0 sampled at an edge: result <= cpu_register_v0 at that same edge; go to DONE.
  - Else, if an enabled edge brings cycle_count to TIMEOUT_CYCLES: timed_out=1, result <= cpu_register_v0, go to DONE.
  - active low and timeout on the same edge: normal completion wins; timed_out stays 0.
  - Step mode with step=0: CPU frozen, no count, no timeout progress.
  - step_mode may toggle mid-run and takes effect that cycle.
- DONE:
  - done=1 for exactly one cycle, cpu_clk_enable=0.
  - Next state IDLE; start in DONE is ignored.
- abort=1 in RST, WAIT_ACT or RUN:
  - Next state IDLE, cpu_clk_enable=0 that cycle, no done pulse.
  - result and flags keep their current values.
  - abort wins over start and over completion in the same cycle.
- start while busy: ignored (no queueing).
- Run-to-done latency, free-run: RESET_CYCLES + (cycles until active) + program cycles + 1.

Decomposition:
- Shared package mips_cpu_run_pkg: state enum (run_state_t), default constants for RESET_CYCLES, TIMEOUT_CYCLES and ACTIVE_WAIT.
- No sub-module. The phase counter is shared between RST and WAIT_ACT and is inline.

Test Plan:
- Free-run addu program, v0=7 after 5 RUN cycles:
  - done pulses once; result=7, cycle_count=5.
  - timed_out=0, no_active=0.
  - cpu_reset high exactly 2 cycles after start.
- Infinite-loop program, TIMEOUT_CYCLES=100:
  - done after the 100th enabled cycle; timed_out=1, cycle_count=100.
  - result = v0 at that edge.
- CPU model holding active=0:
  - no_active=1 two cycles after reset release, then done.
  - result=0; cycle_count=0.
- Step mode, step pulsed 3 times 4 cycles apart:
  - cpu_clk_enable high exactly 3 cycles in RUN; cycle_count=3.
  - No timeout with long idle gaps.
- abort asserted mid-RUN (cycle 10) together with start:
  - IDLE next cycle, no done, busy=0.
  - A later start runs a clean new run with flags cleared.
- Async reset asserted mid-RUN between edges:
  - All outputs 0 immediately, cpu_reset=1 while reset is high.
  - IDLE after release.
